// File: rtl/pixel_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_buffer
// Purpose  : Double-buffered greyscale frame store that feeds the TLC5941
//            pixel serializer. Host subpixels (8 bit) are expanded to 12 bit
//            and written in raster order into the back bank. The serializer
//            reads the front bank with one cycle of latency. The banks
//            exchange only on a serializer frame boundary, and only once a
//            complete back frame is waiting.
// Ports    : clock, reset (async, active high)
//            wr_valid/wr_ready/wr_data/wr_first : host subpixel stream
//            rd_en/rd_row/rd_lane/rd_word       : serializer read request
//            rd_data/rd_valid                   : read response (+1 cycle)
//            swap_req/swapped/frame_pending     : bank exchange handshake
//            err_flag/err_clear                 : sticky restart error
// Options  : PIXEL_FRAME_BUFFER_GAMMA_EN - square-law (gamma 2.0) expansion
//            instead of linear bit replication.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_frame_buffer #(
  parameter int ROWS  = 6,
  parameter int LANES = 12,
  parameter int WORDS = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  input  logic        wr_first,
  input  logic        rd_en,
  input  logic [2:0]  rd_row,
  input  logic [3:0]  rd_lane,
  input  logic [5:0]  rd_word,
  output logic [11:0] rd_data,
  output logic        rd_valid,
  input  logic        swap_req,
  output logic        swapped,
  output logic        frame_pending,
  output logic        err_flag,
  input  logic        err_clear
);

  localparam int FRAME_WORDS = ROWS * LANES * WORDS;
  localparam int ADDR_W      = $clog2(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  // Two banks; contents are deliberately left unreset.
  logic [11:0] mem [0:1][0:FRAME_WORDS-1];

  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              frame_pending_q, frame_pending_d;
  logic              front_q, front_d;
  logic              swapped_q, swapped_d;
  logic              err_q, err_d;
  logic [11:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              wr_fire;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;

  function automatic logic [11:0] expand(input logic [7:0] x);
`ifdef PIXEL_FRAME_BUFFER_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(x) * 16'(x);
    return sq[15:4];
`else
    // Replicating the top nibble maps 0xFF to full scale 0xFFF.
    return {x, x[7:4]};
`endif
  endfunction

  assign wr_ready = !frame_pending_q;
  assign wr_fire  = wr_valid && wr_ready;
  // A frame-start marker always lands at address 0, whatever the counter says.
  assign wr_addr  = wr_first ? '0 : wcnt_q;

  assign rd_in_range = (int'(rd_row) < ROWS) && (int'(rd_lane) < LANES) &&
                       (int'(rd_word) < WORDS);
  assign rd_addr = ADDR_W'((int'(rd_row) * LANES + int'(rd_lane)) * WORDS +
                           int'(rd_word));

  always_comb begin
    wcnt_d          = wcnt_q;
    frame_pending_d = frame_pending_q;
    front_d         = front_q;
    swapped_d       = 1'b0;
    err_d           = err_q;
    rd_data_d       = rd_data_q;
    rd_valid_d      = 1'b0;

    // Clear first so a same-cycle set overrides it.
    if (err_clear) err_d = 1'b0;

    if (wr_fire) begin
      if (wr_first) begin
        wcnt_d = ADDR_W'(1);
        if (wcnt_q != '0) err_d = 1'b1;
      end else if (wcnt_q == LAST_ADDR) begin
        wcnt_d          = '0;
        frame_pending_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + ADDR_W'(1);
      end
    end

    // Pending is only visible from the registered copy, so a swap_req on the
    // edge of the final write is ignored. wr_ready is low whenever a swap can
    // fire, so the two pending updates never collide.
    if (swap_req && frame_pending_q) begin
      front_d         = ~front_q;
      frame_pending_d = 1'b0;
      swapped_d       = 1'b1;
    end

    // Reads use the pre-swap front select: a read on a swap edge sees old data.
    if (rd_en) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_in_range ? mem[front_q][rd_addr] : 12'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt_q          <= '0;
      frame_pending_q <= 1'b0;
      front_q         <= 1'b0;
      swapped_q       <= 1'b0;
      err_q           <= 1'b0;
      rd_data_q       <= 12'd0;
      rd_valid_q      <= 1'b0;
    end else begin
      wcnt_q          <= wcnt_d;
      frame_pending_q <= frame_pending_d;
      front_q         <= front_d;
      swapped_q       <= swapped_d;
      err_q           <= err_d;
      rd_data_q       <= rd_data_d;
      rd_valid_q      <= rd_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) mem[~front_q][wr_addr] <= expand(wr_data);
  end

  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign swapped       = swapped_q;
  assign frame_pending = frame_pending_q;
  assign err_flag      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_frame_buffer
// Purpose  : Self-checking bench for pixel_frame_buffer. Keeps its own model
//            of both banks and the front select; read responses are checked
//            through an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_buffer;

  localparam int FW = 3456;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_data = 8'd0;
  logic        wr_first = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_row = 3'd0;
  logic [3:0]  rd_lane = 4'd0;
  logic [5:0]  rd_word = 6'd0;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        swap_req = 1'b0;
  logic        swapped;
  logic        frame_pending;
  logic        err_flag;
  logic        err_clear = 1'b0;

  pixel_frame_buffer dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_first(wr_first),
    .rd_en(rd_en), .rd_row(rd_row), .rd_lane(rd_lane), .rd_word(rd_word),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .swap_req(swap_req), .swapped(swapped), .frame_pending(frame_pending),
    .err_flag(err_flag), .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  logic [11:0] model [0:1][0:FW-1];
  logic        mfront = 1'b0;
  logic [11:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_expand(input logic [7:0] x);
`ifdef PIXEL_FRAME_BUFFER_GAMMA_EN
    return 12'((int'(x) * int'(x)) / 16);
`else
    return 12'(int'(x) * 16 + int'(x) / 16);
`endif
  endfunction

  // Writes indices start..start+count-1 with value (idx+seed)[7:0].
  task automatic write_seq(input int seed, input int start, input int count,
                           input bit first, input bit clr_first,
                           input bit swap_last);
    for (int i = 0; i < count; i++) begin
      int idx;
      logic [7:0] v;
      idx       = start + i;
      v         = 8'(idx + seed);
      wr_valid  = 1'b1;
      wr_data   = v;
      wr_first  = first && (i == 0);
      err_clear = clr_first && (i == 0);
      swap_req  = swap_last && (i == count - 1);
      @(posedge clock);
      model[~mfront][idx] = ref_expand(v);
      @(negedge clock);
    end
    wr_valid  = 1'b0;
    wr_first  = 1'b0;
    err_clear = 1'b0;
    swap_req  = 1'b0;
  endtask

  // exp_override < 0 selects the model value.
  task automatic read_chk(input string tag, input int row, input int lane,
                          input int word, input bit dchk, input bit with_swap,
                          input int exp_override);
    logic [11:0] e;
    rd_en   = 1'b1;
    rd_row  = 3'(row);
    rd_lane = 4'(lane);
    rd_word = 6'(word);
    if (exp_override >= 0) e = 12'(exp_override);
    else if (row < 6 && lane < 12 && word < 48)
      e = model[mfront][(row * 12 + lane) * 48 + word];
    else e = 12'd0;
    if (dchk) exp_q.push_back(e);
    swap_req = with_swap;
    @(posedge clock);
    @(negedge clock);
    rd_en    = 1'b0;
    swap_req = 1'b0;
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
    if (dchk) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_queue: got empty, want entry", tag);
      end else begin
        check_eq(tag, 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic do_swap(input string tag, input bit expect_swap);
    swap_req = 1'b1;
    @(posedge clock);
    @(negedge clock);
    swap_req = 1'b0;
    check_eq({tag, "_pulse"}, 32'(swapped), 32'(expect_swap));
    check_eq({tag, "_pending"}, 32'(frame_pending), 32'd0);
    if (expect_swap) mfront = ~mfront;
    @(posedge clock);
    @(negedge clock);
    check_eq({tag, "_pulse_end"}, 32'(swapped), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    // 1. reset state
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_pending", 32'(frame_pending), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_swapped", 32'(swapped), 32'd0);
    check_eq("rst_err", 32'(err_flag), 32'd0);
    read_chk("rst_read", 0, 0, 0, 1'b0, 1'b0, -1);
    @(negedge clock);
    check_eq("idle_rd_valid", 32'(rd_valid), 32'd0);

    // 2. full frame; swap_req on the last write edge must be ignored
    write_seq(0, 0, FW - 1, 1'b1, 1'b0, 1'b0);
    check_eq("mid_pending", 32'(frame_pending), 32'd0);
    write_seq(0, FW - 1, 1, 1'b0, 1'b0, 1'b1);
    check_eq("last_swap_ignored", 32'(swapped), 32'd0);
    check_eq("full_pending", 32'(frame_pending), 32'd1);
    check_eq("full_wr_ready", 32'(wr_ready), 32'd0);
    do_swap("swap1", 1'b1);
    check_eq("swap1_wr_ready", 32'(wr_ready), 32'd1);
`ifdef PIXEL_FRAME_BUFFER_GAMMA_EN
    read_chk("rd_677_const", 1, 2, 5, 1'b1, 1'b0, 'h6A5);
`else
    read_chk("rd_677_const", 1, 2, 5, 1'b1, 1'b0, 'hA5A);
`endif
    read_chk("rd_first", 0, 0, 0, 1'b1, 1'b0, -1);
    read_chk("rd_last", 5, 11, 47, 1'b1, 1'b0, -1);
    read_chk("rd_mid", 3, 7, 20, 1'b1, 1'b0, -1);

    // 3. swap with nothing pending
    do_swap("noswap", 1'b0);
    read_chk("noswap_rd", 1, 2, 5, 1'b1, 1'b0, -1);

    // 4. restart mid-frame, error flag, clear, set-vs-clear priority
    write_seq(7, 0, 100, 1'b1, 1'b0, 1'b0);
    check_eq("pre_err", 32'(err_flag), 32'd0);
    write_seq(3, 0, 50, 1'b1, 1'b0, 1'b0);
    check_eq("err_set", 32'(err_flag), 32'd1);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    check_eq("err_cleared", 32'(err_flag), 32'd0);
    write_seq(3, 0, FW, 1'b1, 1'b1, 1'b0);
    check_eq("err_set_wins", 32'(err_flag), 32'd1);
    check_eq("frame2_pending", 32'(frame_pending), 32'd1);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    check_eq("err_cleared2", 32'(err_flag), 32'd0);

    // 5. read on the swap edge sees the old front, then the new one
    read_chk("swap_rd_old", 1, 2, 5, 1'b1, 1'b1, -1);
    check_eq("swap2_pulse", 32'(swapped), 32'd1);
    mfront = ~mfront;
    read_chk("swap_rd_new", 1, 2, 5, 1'b1, 1'b0, -1);
    read_chk("swap_rd_new0", 0, 0, 0, 1'b1, 1'b0, -1);

    // 6. out-of-range reads
    read_chk("oor_lane", 1, 12, 5, 1'b1, 1'b0, -1);
    read_chk("oor_row", 6, 0, 0, 1'b1, 1'b0, -1);
    read_chk("oor_word", 0, 0, 48, 1'b1, 1'b0, -1);

    // reset mid-stream, then a frame without wr_first must land at address 0
    write_seq(9, 0, 200, 1'b1, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check_eq("mrst_pending", 32'(frame_pending), 32'd0);
    check_eq("mrst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("mrst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clock);
    reset  = 1'b0;
    mfront = 1'b0;
    write_seq(11, 0, FW, 1'b0, 1'b0, 1'b0);
    check_eq("mrst_err", 32'(err_flag), 32'd0);
    check_eq("mrst_full_pending", 32'(frame_pending), 32'd1);
    do_swap("swap3", 1'b1);
    read_chk("f3_rd_677", 1, 2, 5, 1'b1, 1'b0, -1);
    read_chk("f3_rd_0", 0, 0, 0, 1'b1, 1'b0, -1);
    read_chk("f3_rd_last", 5, 11, 47, 1'b1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_frame_buffer.md
Name: pixel_frame_buffer

Overview:
Double-buffered greyscale frame store directly upstream of the TLC5941 pixel serializer. A host stream writes 8-bit subpixels into the back bank, and each one is expanded to 12 bits on the way in. The serializer reads 12-bit words from the front bank by (row, lane, word) with one cycle of latency. Banks swap only at a serializer frame boundary, and only once a complete back frame is waiting, so the LEDs never show a torn frame.

Parameters:
ROWS, 6, scan rows per frame
LANES, 12, serial data lanes (6 left + 6 right sin outputs)
WORDS, 48, 12-bit words per lane per row (16 pixels x R,G,B)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
wr_valid  in  1  host subpixel valid
wr_ready  out  1  block accepts subpixel this cycle
wr_data  in  8  host subpixel value
wr_first  in  1  marks first subpixel of a frame; qualified by wr_valid
rd_en  in  1  serializer read strobe
rd_row  in  3  row index
rd_lane  in  4  lane index
rd_word  in  6  word index within lane
rd_data  out  12  greyscale word for the previous cycle's read
rd_valid  out  1  rd_data valid, one cycle after rd_en
swap_req  in  1  one-cycle pulse at serializer frame boundary
swapped  out  1  one-cycle pulse: banks exchanged
frame_pending  out  1  complete back frame awaiting swap
err_flag  out  1  sticky: wr_first arrived mid-frame
err_clear  in  1  clears err_flag

Behaviour:
- Storage: 2 banks x FRAME_WORDS (ROWS*LANES*WORDS = 3456) x 12 bits. Contents are not cleared by reset.
- Reset values:
  - wr_ready=1, rd_data=0, rd_valid=0, swapped=0, frame_pending=0, err_flag=0.
  - Internal front-bank select = 0, so bank 1 is the back bank.
  - Write counter = 0.
  - Reset asserted mid-frame discards the partial frame and any pending frame.
- Address rule, shared by read and write: addr = (row*LANES + lane)*WORDS + word. Write order is raster: word fastest, then lane, then row.
- Write side:
  - A transfer occurs when wr_valid && wr_ready.
  - wr_ready = !frame_pending.
  - On transfer: back[wcnt] <= expand(wr_data), then wcnt increments.
  - wr_first on a transfer forces the write to address 0 and sets wcnt to 1.
  - If wcnt != 0 when wr_first arrives, the partial frame is dropped and err_flag is set.
  - When wcnt reaches FRAME_WORDS-1 and transfers: wcnt wraps to 0 and frame_pending <= 1 on the next edge.
  - Transfers without wr_first at wcnt=0 are accepted as a new frame start; there is no error in that case.
- Swap:
  - Condition: swap_req && frame_pending at the clock edge.
  - Effect: front select toggles, frame_pending <= 0, swapped <= 1 for exactly one cycle.
  - swap_req with frame_pending=0 is ignored, with no pulse.
  - Last write and swap_req on the same edge: no swap that edge, because pending is not yet set.
- Read side:
  - On rd_en, the address is formed from the inputs and front-bank data is registered.
  - rd_data/rd_valid update on the next edge; latency is exactly 1.
  - A read issued on the same edge as a swap returns old-front data.
  - Out-of-range row/lane/word (row>=ROWS, lane>=LANES, word>=WORDS) returns rd_data=0 with rd_valid=1.
  - With rd_en=0: rd_valid=0 and rd_data holds its last value.
- Reads and writes are independent and never stall each other.
- err_flag: set has priority over err_clear in the same cycle.

Optional Feature:
Macro PIXEL_FRAME_BUFFER_GAMMA_EN.
- Defined: expand(x) = (x*x)[15:4], a 16-bit product giving an approximate gamma 2.0 curve (0->0, 16->16, 128->1024, 255->4064).
- Undefined: linear expand(x) = {x, x[7:4]} (0->0, 128->2056, 255->4095).
- Everything else is identical.

Test Plan:
1. Reset, then rd_en at (0,0,0) -> rd_valid=1 one cycle later. frame_pending=0 and wr_ready=1 from reset.
2. Stream 3456 subpixels with value = index[7:0], wr_first on the first, then pulse swap_req.
   - Required: frame_pending=1 and wr_ready=0 after the last write; swapped one cycle; pending clears.
   - Read (row 1, lane 2, word 5) = addr 677, data 0xA5 -> linear 0xA5A, gamma 0x6A5 (165^2>>4 = 1701).
3. swap_req with no pending frame -> no swapped pulse, front data unchanged.
4. wr_first asserted at wcnt=100 -> err_flag=1 and writing restarts at address 0. err_clear -> 0. Simultaneous set/clear -> stays 1.
5. rd_en on the same edge as a swap -> returns old-front word; the next read returns the new frame's word.
6. Read with rd_lane=12 -> rd_data=0, rd_valid=1. Reset asserted mid-stream -> frame_pending=0, wcnt=0, next full frame swaps correctly.
